muldiv_unit: RTL and testbench

Iterative unsigned multiply/divide unit for the processor's execute path. It takes two operands straight from the register-file read ports (`out1`, `out2`) and computes one result bit per cycle. It returns the result with its destination register index as a one-cycle write-back pulse that drives the register file's `wrtEn`/`rd`/`wrtData`. Control logic stalls instruction issue while `busy` is high.

---
 rtl/muldiv_pkg.sv | 27 ++
 rtl/muldiv_step.sv | 51 +++++
 rtl/muldiv_unit.sv | 102 ++++++++++
 tb/tb_muldiv_unit.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and op encoding for the iterative multiply/divide unit.
// MULDIV_DIV_EN enables the divider datapath in the unit that imports this.
package muldiv_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_MULHU = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_REMU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic logic is_div(input logic [1:0] op);
    return (op == OP_DIVU) || (op == OP_REMU);
  endfunction

  // MULHU and REMU both return the upper accumulator register
  function automatic logic take_acc(input logic [1:0] op);
    return (op == OP_MULHU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration: shift-add multiply or restoring divide step.
// The divide path exists only when MULDIV_DIV_EN is defined.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] low,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] acc_n,
  output logic [WIDTH-1:0] low_n
);

  logic [WIDTH:0] sum;

  assign sum = {1'b0, acc} + {1'b0, (low[0] ? opnd : '0)};

`ifdef MULDIV_DIV_EN
  logic [WIDTH:0]   shl;
  logic [WIDTH+1:0] diff;
  logic             unused_bit;

  // WIDTH+1-bit partial remainder; diff MSB is the borrow
  assign shl        = {acc, low[WIDTH-1]};
  assign diff       = {1'b0, shl} - {2'b00, opnd};
  assign unused_bit = diff[WIDTH];

  always_comb begin
    acc_n = sum[WIDTH:1];
    low_n = {sum[0], low[WIDTH-1:1]};
    if (div) begin
      if (diff[WIDTH+1]) begin
        acc_n = shl[WIDTH-1:0];
        low_n = {low[WIDTH-2:0], 1'b0};
      end else begin
        acc_n = diff[WIDTH-1:0];
        low_n = {low[WIDTH-2:0], 1'b1};
      end
    end
  end
`else
  logic unused_div;

  assign unused_div = div;
  assign acc_n      = sum[WIDTH:1];
  assign low_n      = {sum[0], low[WIDTH-1:1]};
`endif

endmodule

// File: rtl/muldiv_unit.sv
// Iterative unsigned MUL/MULHU/DIVU/REMU, one result bit per cycle.
// MULDIV_DIV_EN: when undefined, DIVU/REMU complete at once with 0.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH         = DEFAULT_WIDTH,
  parameter int REG_ADDR_BITS = 4
) (
  input  logic                     clk,
  input  logic                     res,
  input  logic                     start,
  input  logic [1:0]               op,
  input  logic [REG_ADDR_BITS-1:0] rdIn,
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
  output logic                     busy,
  output logic                     done,
  output logic [REG_ADDR_BITS-1:0] rdOut,
  output logic [WIDTH-1:0]         result
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t state, state_n;

  logic [CW-1:0]            cnt;
  logic [1:0]               op_q;
  logic [REG_ADDR_BITS-1:0] rd_q;
  logic [WIDTH-1:0]         acc, low, opnd;
  logic [WIDTH-1:0]         acc_n, low_n;
  logic                     accept;

  assign accept = (state == IDLE) && start;
  assign busy   = (state != IDLE);
  assign done   = (state == DONE);

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .div   (is_div(op_q)),
    .acc   (acc),
    .low   (low),
    .opnd  (opnd),
    .acc_n (acc_n),
    .low_n (low_n)
  );

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (start) begin
`ifdef MULDIV_DIV_EN
          state_n = RUN;
`else
          state_n = is_div(op) ? DONE : RUN;
`endif
        end
      end
      RUN:     if (cnt == LAST) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state  <= IDLE;
      cnt    <= '0;
      op_q   <= '0;
      rd_q   <= '0;
      acc    <= '0;
      low    <= '0;
      opnd   <= '0;
      rdOut  <= '0;
      result <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        op_q <= op;
        rd_q <= rdIn;
        cnt  <= '0;
        acc  <= '0;
        // dividend shifts out of low; multiplier bits consumed from low
        low  <= is_div(op) ? a : b;
        opnd <= is_div(op) ? b : a;
        if (state_n == DONE) begin
          rdOut  <= rdIn;
          result <= '0;
        end
      end else if (state == RUN) begin
        acc <= acc_n;
        low <= low_n;
        cnt <= cnt + 1'b1;
        if (cnt == LAST) begin
          rdOut  <= rd_q;
          result <= take_acc(op_q) ? acc_n : low_n;
        end
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
// Expectations follow MULDIV_DIV_EN the same way the design build does.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         res = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [3:0]   rdIn = 4'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done;
  logic [3:0]   rdOut;
  logic [W-1:0] result;

  int checks = 0;
  int errors = 0;
  int nd, c1, c2, d1;
  logic [W-1:0] r1, r2;
  logic busy_at [0:127];

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W), .REG_ADDR_BITS(4)) dut (
    .clk    (clk),
    .res    (res),
    .start  (start),
    .op     (op),
    .rdIn   (rdIn),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .rdOut  (rdOut),
    .result (result)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Accept one op, then watch ncyc cycles; optionally hold a second
  // start in cycles hlo..hhi and pulse reset in cycle rc.
  task automatic run(input logic [1:0] o, input logic [W-1:0] x, y,
                     input logic [3:0] r, input int hlo, hhi,
                     input logic [1:0] ho, input logic [W-1:0] hx, hy,
                     input int rc, ncyc);
    nd = 0; c1 = -1; c2 = -1; d1 = -1; r1 = 'x; r2 = 'x;
    for (int i = 0; i < 128; i++) busy_at[i] = 1'bx;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y; rdIn = r;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      busy_at[k] = busy;
      if (done === 1'b1) begin
        nd++;
        if (nd == 1) begin c1 = k; r1 = result; d1 = int'(rdOut); end
        else begin c2 = k; r2 = result; end
      end
      start = (k >= hlo) && (k <= hhi);
      op = ho; a = hx; b = hy; rdIn = 4'd9;
      res = (k == rc);
    end
    start = 1'b0;
    res = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    res = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rdout", rdOut, 0);
    chk("rst_result", result, 0);

    run(OP_MUL, 7, 6, 3, 0, -1, OP_MUL, 0, 0, 0, 40);
    chk("mul_ndone", nd, 1);
    chk("mul_cycle", c1, 33);
    chk("mul_result", r1, 42);
    chk("mul_rd", d1, 3);
    chk("mul_busy32", busy_at[32], 1);
    chk("mul_busy34", busy_at[34], 0);

    run(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0, -1, OP_MUL, 0, 0, 0, 36);
    chk("mulmax_result", r1, 32'h0000_0001);
    run(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 0, -1, OP_MUL, 0, 0, 0, 36);
    chk("mulhu_result", r1, 32'hFFFF_FFFE);
    chk("mulhu_cycle", c1, 33);

`ifdef MULDIV_DIV_EN
    run(OP_DIVU, 100, 7, 4, 0, -1, OP_MUL, 0, 0, 0, 36);
    chk("divu_result", r1, 14);
    chk("divu_cycle", c1, 33);
    run(OP_REMU, 100, 7, 5, 0, -1, OP_MUL, 0, 0, 0, 36);
    chk("remu_result", r1, 2);
    run(OP_DIVU, 32'h1234, 0, 6, 0, -1, OP_MUL, 0, 0, 0, 36);
    chk("divz_result", r1, 32'hFFFF_FFFF);
    run(OP_REMU, 32'h1234, 0, 7, 0, -1, OP_MUL, 0, 0, 0, 36);
    chk("remz_result", r1, 32'h1234);
`else
    run(OP_DIVU, 100, 7, 4, 0, -1, OP_MUL, 0, 0, 0, 10);
    chk("divu_off_cycle", c1, 1);
    chk("divu_off_result", r1, 0);
    chk("divu_off_rd", d1, 4);
    chk("divu_off_busy2", busy_at[2], 0);
    run(OP_REMU, 100, 7, 5, 0, -1, OP_MUL, 0, 0, 0, 10);
    chk("remu_off_result", r1, 0);
    chk("remu_off_ndone", nd, 1);
`endif

    run(OP_MUL, 3, 5, 8, 5, 33, OP_DIVU, 9, 3, 0, 80);
    chk("hold_ndone", nd, 1);
    chk("hold_cycle", c1, 33);
    chk("hold_result", r1, 15);

    run(OP_MUL, 3, 5, 8, 5, 34, OP_DIVU, 9, 3, 0, 80);
    chk("hold34_ndone", nd, 2);
    chk("hold34_first", r1, 15);
`ifdef MULDIV_DIV_EN
    chk("hold34_cycle2", c2, 67);
    chk("hold34_result2", r2, 3);
`else
    chk("hold34_cycle2", c2, 35);
    chk("hold34_result2", r2, 0);
`endif

    run(OP_MUL, 3, 5, 10, 0, -1, OP_MUL, 0, 0, 10, 40);
    chk("rstmid_busy10", busy_at[10], 1);
    chk("rstmid_busy11", busy_at[11], 0);
    chk("rstmid_ndone", nd, 0);
    run(OP_MUL, 7, 6, 11, 0, -1, OP_MUL, 0, 0, 0, 36);
    chk("after_rst_result", r1, 42);
    chk("after_rst_cycle", c1, 33);

    @(negedge clk);
    start = 1'b1; res = 1'b1; op = OP_MUL; a = 2; b = 2;
    @(negedge clk);
    start = 1'b0; res = 1'b0;
    chk("rst_start_busy", busy, 0);
    chk("rst_start_done", done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
